// File: rtl/pad_ctrl_pkg.sv
// Shared definitions for the pad control bank: register map, PAD field
// layout and commit sequencer states.
package pad_ctrl_pkg;

    localparam logic [11:0] OFF_CTRL   = 12'h200;
    localparam logic [11:0] OFF_STATUS = 12'h204;
    localparam logic [11:0] OFF_SETTLE = 12'h208;

    localparam int unsigned PAD_OEN_BIT  = 0;
    localparam int unsigned PAD_REN_BIT  = 1;
    localparam int unsigned PAD_LOCK_BIT = 2;
    localparam int unsigned PAD_AOEN_BIT = 4;
    localparam int unsigned PAD_AREN_BIT = 5;

    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_PEND_BIT = 1;
    localparam int unsigned STAT_ERR_BIT  = 2;

    localparam int unsigned CTRL_COMMIT_BIT = 0;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RELEASE,
        SEQ_SETTLE,
        SEQ_DRIVE
    } seq_state_e;

endpackage

// File: rtl/pad_ctrl_seq.sv
// Commit sequencer: release outputs, wait the settle time, then drive the
// shadow configuration onto the active pads. One further commit may queue.
module pad_ctrl_seq
    import pad_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       resetb,
    input  logic       commit,
    input  logic [7:0] settle_val,
    output logic       busy,
    output logic       pending,
    output logic       release_en,
    output logic       drive_en,
    output logic       irq
);

    seq_state_e state_q, state_d;
    logic [7:0] cnt_q;
    logic       pend_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == SEQ_RELEASE)
                cnt_q <= settle_val;
            else if (state_q == SEQ_SETTLE && cnt_q != 8'd0)
                cnt_q <= cnt_q - 8'd1;
            // DRIVE consumes the queued commit; one arriving in that same
            // cycle with another already queued stays queued.
            if (state_q == SEQ_DRIVE)
                pend_q <= pend_q & commit;
            else if (state_q != SEQ_IDLE && commit)
                pend_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        release_en = 1'b0;
        drive_en   = 1'b0;
        irq        = 1'b0;
        case (state_q)
            SEQ_IDLE:    if (commit) state_d = SEQ_RELEASE;
            SEQ_RELEASE: begin
                release_en = 1'b1;
                state_d    = SEQ_SETTLE;
            end
            SEQ_SETTLE:  if (cnt_q == 8'd0) state_d = SEQ_DRIVE;
            SEQ_DRIVE: begin
                drive_en = 1'b1;
                irq      = 1'b1;
                state_d  = (pend_q || commit) ? SEQ_RELEASE : SEQ_IDLE;
            end
            default:     state_d = SEQ_IDLE;
        endcase
    end

    assign busy    = (state_q != SEQ_IDLE);
    assign pending = pend_q;

endmodule

// File: rtl/pad_ctrl_bank.sv
// Wishbone-mapped pad output-enable / pull-enable bank with shadow registers,
// per-pad lock and a glitch-safe commit sequence.
module pad_ctrl_bank
    import pad_ctrl_pkg::*;
#(
    parameter int unsigned         NUM_PADS   = 38,
    parameter logic [19:0]         BASE_HI    = 20'h30006,
    parameter logic [NUM_PADS-1:0] RST_OEN    = 38'h00_3FBF_81BD,
    parameter logic [NUM_PADS-1:0] RST_REN    = '1,
    parameter logic [7:0]          RST_SETTLE = 8'd4
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [NUM_PADS-1:0] oe_n,
    output logic [NUM_PADS-1:0] re_n,
    output logic                irq
);

    logic [NUM_PADS-1:0] shadow_oen, shadow_ren, lock;
    logic [NUM_PADS-1:0] active_oen, active_ren;
    logic [7:0]          settle_q;
    logic                err_q;
    logic [31:0]         rdata;

    logic        busy, pending, release_en, drive_en;
    logic [11:0] off;
    logic        acc, wr, pad_hit, pad_wr, commit;

    assign off     = wbs_adr_i[11:0];
    assign acc     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_HI) & ~wbs_ack_o;
    assign wr      = acc & wbs_we_i & wbs_sel_i[0];
    assign pad_hit = (off[11:8] == 4'd0) && (off[1:0] == 2'b00) && (32'(off[7:2]) < NUM_PADS);
    assign pad_wr  = wr & ~busy & pad_hit;
    assign commit  = wr & (off == OFF_CTRL) & wbs_dat_i[CTRL_COMMIT_BIT];

    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_sel_i[3:1], wbs_dat_i[31:8]};

    pad_ctrl_seq u_seq (
        .clk        (clk),
        .resetb     (resetb),
        .commit     (commit),
        .settle_val (settle_q),
        .busy       (busy),
        .pending    (pending),
        .release_en (release_en),
        .drive_en   (drive_en),
        .irq        (irq)
    );

    // Shadow fields use the lock state before this write, so the write that
    // sets lock still lands its own shadow bits.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            shadow_oen <= RST_OEN;
            shadow_ren <= RST_REN;
            lock       <= '0;
        end else if (pad_wr) begin
            for (int unsigned i = 0; i < NUM_PADS; i++) begin
                if (off[7:2] == 6'(i)) begin
                    if (!lock[i]) begin
                        shadow_oen[i] <= wbs_dat_i[PAD_OEN_BIT];
                        shadow_ren[i] <= wbs_dat_i[PAD_REN_BIT];
                    end
                    if (wbs_dat_i[PAD_LOCK_BIT])
                        lock[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            active_oen <= RST_OEN;
            active_ren <= RST_REN;
        end else if (release_en) begin
            active_oen <= active_oen | (shadow_oen & ~lock);
        end else if (drive_en) begin
            active_oen <= (active_oen & lock) | (shadow_oen & ~lock);
            active_ren <= (active_ren & lock) | (shadow_ren & ~lock);
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            settle_q <= RST_SETTLE;
            err_q    <= 1'b0;
        end else begin
            if (wr && !busy && off == OFF_SETTLE)
                settle_q <= wbs_dat_i[7:0];
            if (wr && busy && (pad_hit || off == OFF_SETTLE))
                err_q <= 1'b1;
            else if (wr && off == OFF_STATUS && wbs_dat_i[STAT_ERR_BIT])
                err_q <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:   rdata = '0;
            OFF_STATUS: begin
                rdata[STAT_BUSY_BIT] = busy;
                rdata[STAT_PEND_BIT] = pending;
                rdata[STAT_ERR_BIT]  = err_q;
            end
            OFF_SETTLE: rdata[7:0] = settle_q;
            default: begin
                for (int unsigned i = 0; i < NUM_PADS; i++) begin
                    if (pad_hit && off[7:2] == 6'(i)) begin
                        rdata[PAD_OEN_BIT]  = shadow_oen[i];
                        rdata[PAD_REN_BIT]  = shadow_ren[i];
                        rdata[PAD_LOCK_BIT] = lock[i];
                        rdata[PAD_AOEN_BIT] = active_oen[i];
                        rdata[PAD_AREN_BIT] = active_ren[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= acc;
            if (acc && !wbs_we_i)
                wbs_dat_o <= rdata;
        end
    end

    assign oe_n = active_oen | {NUM_PADS{~resetb}};
    assign re_n = active_ren & {NUM_PADS{resetb}};

endmodule
